// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode map, controller states and
// the rule deciding which operations run on the iterative datapath.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_AND = 3'b110,
        OP_OR  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Division by zero short-circuits to a single-cycle result.
    function automatic logic is_iterative(input alu_op_t op, input logic divisor_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared shift-add multiplier / restoring divider, one bit per clock.
// Result ports show the outcome of the step performed in the current cycle.
module alu_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ITERS = CW'(WIDTH);

    logic [CW-1:0]      cnt;
    logic               div_mode;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;

    // Divide mode keeps {remainder, quotient} in acc; the dividend shifts
    // out of the low half as quotient bits shift in.
    always_comb begin
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, opnd};
        ge       = (shifted >= {1'b0, opnd});
        acc_next = acc;
        if (div_mode) begin
            acc_next = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], ge};
        end else begin
            acc_next = acc + (opnd[0] ? mcand : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div_mode <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            opnd     <= '0;
        end else if (start) begin
            cnt      <= ITERS;
            div_mode <= is_div;
            opnd     <= b;
            acc      <= is_div ? {{WIDTH{1'b0}}, a} : '0;
            mcand    <= {{WIDTH{1'b0}}, a};
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            acc <= acc_next;
            if (!div_mode) begin
                mcand <= mcand << 1;
                opnd  <= opnd >> 1;
            end
        end
    end

    assign done      = (cnt == CW'(1));
    assign product   = acc_next;
    assign quotient  = acc_next[WIDTH-1:0];
    assign remainder = acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides and registered result/flags.
//   state | meaning
//   IDLE  | no result held, ready for an operation
//   BUSY  | mul/div iterating, input side stalled
//   DONE  | result held on out until the consumer takes it
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               cflag,
    output logic               zflag,
    output logic               dzflag
);

    alu_state_t         state, state_next;
    alu_op_t            op;
    logic               accept;
    logic               iterative;
    logic               load_single;
    logic               load_iter;
    logic               is_div_q;
    logic               iter_done;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] iter_res;
    logic [2*WIDTH-1:0] single_res;
    logic               single_c;
    logic               single_dz;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;

    assign op          = alu_op_t'(sel);
    assign iterative   = is_iterative(op, (b == '0));
    assign in_ready    = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state == DONE);
    assign load_single = accept && !iterative;
    assign load_iter   = (state == BUSY) && iter_done;
    assign iter_res    = is_div_q ? {rem, quo} : prod;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && iterative),
        .is_div    (op == OP_DIV),
        .a         (a),
        .b         (b),
        .done      (iter_done),
        .product   (prod),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        sum        = {1'b0, a} + {1'b0, b};
        dif        = {1'b0, a} - {1'b0, b};
        single_res = '0;
        single_c   = 1'b0;
        single_dz  = 1'b0;
        case (op)
            OP_ADD: begin
                single_res[WIDTH:0] = sum;
                single_c            = sum[WIDTH];
            end
            OP_SUB: begin
                single_res[WIDTH-1:0] = dif[WIDTH-1:0];
                single_c              = dif[WIDTH];
            end
            // Only reached with b == 0; nonzero divisors go to the iterator.
            OP_DIV: begin
                single_res = {a, {WIDTH{1'b1}}};
                single_dz  = 1'b1;
            end
            OP_SHL: begin
                single_res[WIDTH-1:0] = {a[WIDTH-2:0], 1'b0};
                single_c              = a[WIDTH-1];
            end
            OP_SHR: begin
                single_res[WIDTH-1:0] = {1'b0, a[WIDTH-1:1]};
                single_c              = a[0];
            end
            OP_AND:  single_res[WIDTH-1:0] = a & b;
            OP_OR:   single_res[WIDTH-1:0] = a | b;
            default: begin end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = iterative ? BUSY : DONE;
            BUSY: if (iter_done) state_next = DONE;
            DONE: begin
                if (accept)         state_next = iterative ? BUSY : DONE;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            is_div_q <= 1'b0;
            out      <= '0;
            cflag    <= 1'b0;
            zflag    <= 1'b0;
            dzflag   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && iterative) is_div_q <= (op == OP_DIV);
            if (load_single) begin
                out    <= single_res;
                cflag  <= single_c;
                zflag  <= (single_res == '0);
                dzflag <= single_dz;
            end else if (load_iter) begin
                out    <= iter_res;
                cflag  <= !is_div_q && (prod[2*WIDTH-1:WIDTH] != '0);
                zflag  <= (iter_res == '0);
                dzflag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, backpressure, reset
// during a multiply, and randomized ops against an arithmetic reference.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2:0]     sel;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out;
    logic           cflag;
    logic           zflag;
    logic           dzflag;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cflag     (cflag),
        .zflag     (zflag),
        .dzflag    (dzflag)
    );

    always #5 clk = ~clk;

    task automatic ref_model(input logic [2:0] op, input int av, input int bv,
                             output logic [2*W-1:0] r, output logic c,
                             output logic z, output logic dz);
        int t;
        t  = 0;
        c  = 1'b0;
        dz = 1'b0;
        case (op)
            3'd0: begin t = av + bv; c = (t >= MOD); end
            3'd1: begin t = av - bv; c = (av < bv); if (t < 0) t += MOD; end
            3'd2: begin t = av * bv; c = (t >= MOD); end
            3'd3: begin
                if (bv == 0) begin t = av * MOD + (MOD - 1); dz = 1'b1; end
                else t = (av % bv) * MOD + (av / bv);
            end
            3'd4: begin t = (av * 2) % MOD; c = (av >= MOD / 2); end
            3'd5: begin t = av / 2; c = ((av % 2) != 0); end
            3'd6: t = av & bv;
            default: t = av | bv;
        endcase
        r = t[2*W-1:0];
        z = (t == 0);
    endtask

    // Presents one op, accepts it at the next edge, and returns the number of
    // edges after the accept edge until out_valid (-1 on timeout).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv, output int lat);
        in_valid = 1'b1; sel = op; a = av; b = bv;
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); sel = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out, cflag, zflag, dzflag} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b out=%h c=%b z=%b dz=%b want all 0",
                     out_valid, out, cflag, zflag, dzflag);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL post_reset: got ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_add_sub();
        int lat;
        out_ready = 1'b1;
        issue(OP_ADD, 8'd200, 8'd100, lat);
        total++;
        if (lat !== 0) begin bad++; $display("FAIL add_latency: got %0d want 0", lat); end
        total++;
        if ({out, cflag, zflag, dzflag} !== {16'h012C, 3'b100}) begin
            bad++; $display("FAIL add_result: got out=%h c=%b z=%b dz=%b want 012c 1 0 0", out, cflag, zflag, dzflag);
        end
        issue(OP_SUB, 8'd5, 8'd7, lat);
        total++;
        if ({out, cflag, zflag, dzflag} !== {16'h00FE, 3'b100}) begin
            bad++; $display("FAIL sub_borrow: got out=%h c=%b z=%b dz=%b want 00fe 1 0 0", out, cflag, zflag, dzflag);
        end
        issue(OP_SUB, 8'd7, 8'd7, lat);
        total++;
        if ({out, cflag, zflag, dzflag} !== {16'h0000, 3'b010}) begin
            bad++; $display("FAIL sub_zero: got out=%h c=%b z=%b dz=%b want 0000 0 1 0", out, cflag, zflag, dzflag);
        end
    endtask

    task automatic test_mul();
        int cyc;
        int low;
        out_ready = 1'b1;
        in_valid = 1'b1; sel = OP_MUL; a = 8'd255; b = 8'd255;
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        cyc = 0;
        low = 0;
        while (!out_valid && cyc < 4 * W) begin
            if (!in_ready) low++;
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc !== W) begin bad++; $display("FAIL mul_latency: got %0d want %0d", cyc, W); end
        total++;
        if (low !== W) begin bad++; $display("FAIL mul_in_ready_low: got %0d cycles want %0d", low, W); end
        total++;
        if ({out, cflag, zflag, dzflag} !== {16'hFE01, 3'b100}) begin
            bad++; $display("FAIL mul_result: got out=%h c=%b z=%b dz=%b want fe01 1 0 0", out, cflag, zflag, dzflag);
        end
    endtask

    task automatic test_div();
        int lat;
        out_ready = 1'b1;
        issue(OP_DIV, 8'd100, 8'd7, lat);
        total++;
        if (lat !== W) begin bad++; $display("FAIL div_latency: got %0d want %0d", lat, W); end
        total++;
        if ({out, cflag, zflag, dzflag} !== {16'h020E, 3'b000}) begin
            bad++; $display("FAIL div_result: got out=%h c=%b z=%b dz=%b want 020e 0 0 0", out, cflag, zflag, dzflag);
        end
        issue(OP_DIV, 8'd100, 8'd0, lat);
        total++;
        if (lat !== 0) begin bad++; $display("FAIL divzero_latency: got %0d want 0", lat); end
        total++;
        if ({out, cflag, zflag, dzflag} !== {16'h64FF, 3'b001}) begin
            bad++; $display("FAIL divzero_result: got out=%h c=%b z=%b dz=%b want 64ff 0 0 1", out, cflag, zflag, dzflag);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(OP_AND, 8'hC3, 8'h5A, lat);
        total++;
        if ({out, cflag, zflag, dzflag} !== {16'h0042, 3'b000}) begin
            bad++; $display("FAIL and_result: got out=%h c=%b z=%b dz=%b want 0042 0 0 0", out, cflag, zflag, dzflag);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, out, cflag, zflag, dzflag} !== {2'b10, 16'h0042, 3'b000}) begin
                bad++;
                $display("FAIL hold_stable[%0d]: got valid=%b ready=%b out=%h c=%b z=%b dz=%b want 1 0 0042 0 0 0",
                         i, out_valid, in_ready, out, cflag, zflag, dzflag);
            end
        end
        in_valid = 1'b1; sel = OP_ADD; a = 8'hFF; b = 8'h01; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if ({out_valid, out, cflag, zflag, dzflag} !== {1'b1, 16'h0100, 3'b100}) begin
            bad++; $display("FAIL b2b_add: got valid=%b out=%h c=%b z=%b dz=%b want 1 0100 1 0 0",
                            out_valid, out, cflag, zflag, dzflag);
        end
        issue(OP_MUL, 8'd3, 8'd5, lat);
        total++;
        if ({lat, out, cflag, zflag, dzflag} !== {W, 16'h000F, 3'b000}) begin
            bad++; $display("FAIL b2b_mul: got lat=%0d out=%h c=%b z=%b want %0d 000f 0 0", lat, out, cflag, zflag, W);
        end
    endtask

    task automatic test_random();
        int lat, av, bv, exp_lat, hold;
        logic [2:0] op;
        logic [2*W-1:0] r;
        logic c, z, dz;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            av = $urandom_range(0, MOD - 1);
            bv = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, MOD - 1);
            if ($urandom_range(0, 7) == 0) av = 0;
            ref_model(op, av, bv, r, c, z, dz);
            exp_lat = (op == 3'd2 || (op == 3'd3 && bv != 0)) ? W : 0;
            issue(op, W'(av), W'(bv), lat);
            total++;
            if (lat !== exp_lat) begin
                bad++; $display("FAIL rand_latency op=%0d a=%0d b=%0d: got %0d want %0d", op, av, bv, lat, exp_lat);
            end
            total++;
            if ({out, cflag, zflag, dzflag} !== {r, c, z, dz}) begin
                bad++;
                $display("FAIL rand_result op=%0d a=%0d b=%0d: got out=%h c=%b z=%b dz=%b want %h %b %b %b",
                         op, av, bv, out, cflag, zflag, dzflag, r, c, z, dz);
            end
            hold = $urandom_range(0, 3);
            if (hold != 0) begin
                out_ready = 1'b0;
                repeat (hold) begin
                    @(posedge clk); #1;
                    total++;
                    if ({out_valid, out, cflag, zflag, dzflag} !== {1'b1, r, c, z, dz}) begin
                        bad++; $display("FAIL rand_hold: got valid=%b out=%h want 1 %h", out_valid, out, r);
                    end
                end
                out_ready = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        int seen;
        out_ready = 1'b1;
        issue(OP_OR, 8'hF0, 8'h0F, lat);
        total++;
        if (out !== 16'h00FF) begin bad++; $display("FAIL pre_abort_or: got %h want 00ff", out); end
        in_valid = 1'b1; sel = OP_MUL; a = 8'd200; b = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out, cflag, zflag, dzflag} !== '0) begin
            bad++; $display("FAIL abort_outputs: got valid=%b out=%h c=%b z=%b dz=%b want all 0",
                            out_valid, out, cflag, zflag, dzflag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (2 * W + 2) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); end
        issue(OP_ADD, 8'd20, 8'd22, lat);
        total++;
        if ({lat, out, cflag, zflag, dzflag} !== {32'd0, 16'd42, 3'b000}) begin
            bad++; $display("FAIL after_abort_add: got lat=%0d out=%h want 0 002a", lat, out);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_back_to_back();
        test_random();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
